// File: rtl/bram_reader_pkg.sv
// -----------------------------------------------------------------------------
// bram_reader_pkg
// Shared definitions for the shared-BRAM packet reader:
//   - state_t          : reader FSM states
//   - LEN_LSB / LEN_W  : position and width of the LEN field in the header word
//   - PREFETCH_DEPTH   : entries in the optional prefetch FIFO
// -----------------------------------------------------------------------------
package bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        FETCH    = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int LEN_LSB        = 0;
    localparam int LEN_W          = 16;
    localparam int PREFETCH_DEPTH = 4;

endpackage : bram_reader_pkg

// File: rtl/bram_reader_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// bram_reader_prefetch_fifo
// Small synchronous FIFO that buffers payload words returned by the BRAM and
// tracks reads that are still in flight, so the reader can keep the BRAM busy
// without ever overrunning the storage.  Only compiled when the macro
// BRAM_PACKET_READER_PREFETCH_EN is defined.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_issue        a payload read is being issued this edge
//   i_wr_en        returned BRAM word is valid this edge
//   i_wr_data      returned BRAM word
//   i_rd_en        head word is consumed this edge
//   o_rd_data      head word
//   o_empty        FIFO holds no words
//   o_can_issue    another read may be issued without exceeding DEPTH credits
// -----------------------------------------------------------------------------
`ifdef BRAM_PACKET_READER_PREFETCH_EN
module bram_reader_prefetch_fifo
    import bram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = PREFETCH_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_issue,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_empty,
    output logic                  o_can_issue
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_inflight;
    logic [CNT_W:0]        w_committed;

    // Credits still held after this edge's pop, excluding a new issue; the
    // word returning this edge moves from in-flight to occupancy, so it is
    // already counted once.
    assign w_committed = {1'b0, r_count} + {1'b0, r_inflight}
                       - {{CNT_W{1'b0}}, i_rd_en};
    assign o_can_issue = (w_committed < (CNT_W+1)'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_rd_data   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({i_issue, i_wr_en})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule : bram_reader_prefetch_fifo
`endif

// File: rtl/bram_packet_reader.sv
// -----------------------------------------------------------------------------
// bram_packet_reader
// PL-side reader for the PS<->PL shared-BRAM channel.  On a start pulse it
// reads a length-prefixed packet (header LEN = word[15:0] at base_address,
// payload at base_address+1 .. base_address+LEN, addresses modulo
// 2^(ADDR_WIDTH+1)) and streams the payload over valid/ready.
//
// Optional feature macro: BRAM_PACKET_READER_PREFETCH_EN
//   defined   : 4-entry prefetch FIFO, back-to-back reads
//   undefined : one outstanding read at a time, no FIFO storage
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   start           one-cycle request, sampled in IDLE only
//   base_address    header location, latched on accepted start
//   busy            high from the cycle after start through the done cycle
//   done, error     one-cycle completion pulse; error=1 when LEN > MAX_LEN
//   rd_address      registered BRAM read address
//   rd_enable       one-cycle strobe per read request
//   rd_data         BRAM read data, RD_LATENCY edges after the request edge
//   out_data        payload word
//   out_valid       payload word available
//   out_ready       consumer accepts the word
//   out_last        final payload word, qualified by out_valid
// -----------------------------------------------------------------------------
module bram_packet_reader
    import bram_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 3,
    parameter int MAX_LEN    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   base_address,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   rd_address,
    output logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int                PIPE_W    = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
    localparam logic [ADDR_WIDTH:0] ADDR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PIPE_W-1:0] r_rd_pipe;
    logic [PIPE_W:0]   w_rd_chain;
    logic              w_rd_vld;
    logic [LEN_W-1:0]  w_len;
    logic              w_len_zero;
    logic              w_len_over;
    logic [LEN_W-1:0]  r_remaining;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_accept;
    logic              w_hdr_ok;
    logic              w_issue;
    logic              w_done_set;
    logic              w_err_set;

    // Read-return tracker: rd_enable shifted so that w_rd_vld is high exactly
    // on the edge that samples the data for that request.  Clearing it on
    // reset discards any read still in flight.
    assign w_rd_chain = {r_rd_pipe, rd_enable};
    assign w_rd_vld   = w_rd_chain[RD_LATENCY-1];

    assign w_len       = rd_data[LEN_LSB +: LEN_W];
    assign w_len_zero  = (w_len == '0);
    assign w_len_over  = (w_len > MAX_LEN_V);
    assign w_beat      = out_valid && out_ready;
    assign w_last_beat = w_beat && (r_remaining == LEN_ONE);
    assign out_last    = out_valid && (r_remaining == LEN_ONE);

`ifdef BRAM_PACKET_READER_PREFETCH_EN
    logic [LEN_W-1:0]      r_to_issue;
    logic                  w_can_issue;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_head;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:     if (start) w_state_nxt = HDR_WAIT;
            HDR_WAIT: if (w_rd_vld) w_state_nxt = (w_len_zero || w_len_over) ? DONE : FETCH;
            FETCH:    if (w_last_beat) w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs (next values for the registered control signals)
    always_comb begin
        w_accept   = 1'b0;
        w_hdr_ok   = 1'b0;
        w_issue    = 1'b0;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            IDLE: w_accept = start;
            HDR_WAIT: begin
                if (w_rd_vld) begin
                    w_done_set = w_len_zero || w_len_over;
                    w_err_set  = w_len_over;
                    w_hdr_ok   = !(w_len_zero || w_len_over);
                    // The first payload read goes out on the header edge.
                    w_issue    = !(w_len_zero || w_len_over);
                end
            end
            FETCH: begin
                w_done_set = w_last_beat;
`ifdef BRAM_PACKET_READER_PREFETCH_EN
                w_issue    = (r_to_issue != '0) && w_can_issue;
`else
                // Next word is requested right after the current one is taken.
                w_issue    = w_beat && (r_remaining != LEN_ONE);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            rd_enable   <= 1'b0;
            rd_address  <= '0;
            r_remaining <= '0;
            r_rd_pipe   <= '0;
        end else begin
            busy      <= (w_state_nxt != IDLE);
            done      <= w_done_set;
            error     <= w_err_set;
            rd_enable <= w_accept || w_issue;
            r_rd_pipe <= w_rd_chain[PIPE_W-1:0];
            // rd_address always holds the last requested address, so the next
            // payload address is simply one more (wrapping naturally).
            if (w_accept) begin
                rd_address <= base_address;
            end else if (w_issue) begin
                rd_address <= rd_address + ADDR_ONE;
            end
            if (w_hdr_ok) begin
                r_remaining <= w_len;
            end else if (w_beat) begin
                r_remaining <= r_remaining - LEN_ONE;
            end
        end
    end

`ifdef BRAM_PACKET_READER_PREFETCH_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_issue <= '0;
        end else if (w_hdr_ok) begin
            r_to_issue <= w_len - LEN_ONE;
        end else if (w_issue) begin
            r_to_issue <= r_to_issue - LEN_ONE;
        end
    end

    bram_reader_prefetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PREFETCH_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_issue     (w_issue),
        .i_wr_en     (w_rd_vld && (r_state == FETCH)),
        .i_wr_data   (rd_data),
        .i_rd_en     (w_beat),
        .o_rd_data   (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_can_issue (w_can_issue)
    );

    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_head;
`else
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if ((r_state == FETCH) && w_rd_vld) begin
            r_out_valid <= 1'b1;
            r_out_data  <= rd_data;
        end else if (w_beat) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
`endif

endmodule : bram_packet_reader

// File: tb/tb_bram_packet_reader.sv
`timescale 1ns/1ps
module tb_bram_packet_reader;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 3;
    localparam int ML = 1024;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [AW:0]     base_address = '0;
    logic            busy, done, error, rd_enable, out_valid, out_last;
    logic            out_ready = 1'b1;
    logic [AW:0]     rd_address;
    logic [DW-1:0]   rd_data, out_data;

    bram_packet_reader #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RD_LATENCY (RL), .MAX_LEN (ML)
    ) dut (
        .clk (clk), .reset_n (reset_n), .start (start), .base_address (base_address),
        .busy (busy), .done (done), .error (error),
        .rd_address (rd_address), .rd_enable (rd_enable), .rd_data (rd_data),
        .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
        .out_last (out_last)
    );

    initial forever #5 clk = ~clk;

    // BRAM model: data for the address registered at edge E is sampled at E+RL.
    logic [DW-1:0] mem [0:8191];
    logic [DW-1:0] rd_pipe [RL-1];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[rd_address];
        for (int i = 1; i < RL - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data = rd_pipe[RL-2];

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [AW:0] base; int len; int mode; logic exp_err; } vec_t;

    beat_t        q_exp[$];
    logic [AW:0]  q_addr[$];
    int           n_cmp = 0, n_bad = 0;
    int           done_cnt = 0, beats_seen = 0;
    int           rdy_mode = 0, pidx = 0;
    logic [6:0]   pat = 7'b1101001;   // 1,0,0,1,0,1,1 read from bit 0 upward

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Consumer ready driver
    initial begin
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                1: begin
                    out_ready = (pidx < 7) ? pat[pidx] : 1'b1;
                    if (out_valid) pidx++;
                end
                2: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic          stall_pend = 1'b0;
        logic [DW-1:0] stall_data = '0;
        logic          stall_last = 1'b0;
        beat_t         b;
        logic [AW:0]   a;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, stall_data);
                    chk("stall_last", out_last, stall_last);
                end
                if (rd_enable) begin
                    if (q_addr.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_read: addr 0x%0h with none expected", rd_address);
                    end else begin
                        a = q_addr.pop_front();
                        chk("rd_address", rd_address, a);
                    end
                end
                if (out_valid && out_ready) begin
                    beats_seen++;
                    if (q_exp.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_beat: data 0x%0h with none expected", out_data);
                    end else begin
                        b = q_exp.pop_front();
                        chk("beat_data", out_data, b.data);
                        chk("beat_last", out_last, b.last);
                    end
                end
                stall_pend = out_valid && !out_ready;
                stall_data = out_data;
                stall_last = out_last;
                if (done) done_cnt++;
            end
        end
    end

    task automatic pulse_start(input logic [AW:0] base);
        @(posedge clk); #1;
        start = 1'b1; base_address = base;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hdr_addr", rd_address, base);
        chk("hdr_rden", rd_enable, 1);
        chk("busy_set", busy, 1);
    endtask

    task automatic run_pkt(input logic [AW:0] base, input int len, input int mode, input logic exp_err);
        logic [AW:0]   a;
        logic [DW-1:0] w;
        int            d0, lim;
        bit            seen;
        mem[base] = {16'hA5C3, 16'(len)};
        q_addr.push_back(base);
        if (len > 0 && len <= ML) begin
            for (int k = 1; k <= len; k++) begin
                a = base + (AW+1)'(k);
                w = $urandom;
                mem[a] = w;
                q_addr.push_back(a);
                q_exp.push_back('{w, (k == len)});
            end
        end
        rdy_mode = mode; pidx = 0;
        d0 = done_cnt;
        pulse_start(base);
        seen = 1'b0;
        lim = 100 + 16 * len;
        for (int c = 0; c < lim; c++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles (base 0x%0h len %0d)", lim, base, len);
            reset_n = 1'b0; #1;
            q_exp.delete(); q_addr.delete();
            @(posedge clk); #1; reset_n = 1'b1;
        end else begin
            chk("error", error, exp_err);
            chk("busy_in_done", busy, 1);
            @(posedge clk); #1;
            chk("busy_after", busy, 0);
            chk("done_width", done, 0);
            chk("beats_left", q_exp.size(), 0);
            chk("reads_left", q_addr.size(), 0);
            chk("done_count", done_cnt - d0, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        bit   hit;
        int   b0;
        vecs[0] = '{13'h0010, 3,    0, 1'b0};   // basic
        vecs[1] = '{13'h0100, 0,    0, 1'b0};   // empty
        vecs[2] = '{13'h0200, 1025, 0, 1'b1};   // oversize
        vecs[3] = '{13'h1FFE, 2,    0, 1'b0};   // wrap
        vecs[4] = '{13'h0300, 4,    1, 1'b0};   // backpressure pattern
        vecs[5] = '{13'h0800, 1024, 0, 1'b0};   // largest legal
        vecs[6] = '{13'h1F00, 300,  2, 1'b0};   // wrap with random ready
        vecs[7] = '{13'h0020, 1,    1, 1'b0};   // single word

        for (int i = 0; i < 8192; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rden", rd_enable, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr", rd_address, 0);
        chk("rst_data", out_data, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_pkt(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].exp_err);
        end

        // Empty packet: done high exactly in the cycle after the header edge
        mem[13'h0050] = 32'hFFFF_0000;
        q_addr.push_back(13'h0050);
        rdy_mode = 0;
        pulse_start(13'h0050);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("empty_done_early", done, 0);
        @(posedge clk); #1;
        chk("empty_done", done, 1);
        chk("empty_error", error, 0);
        chk("empty_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("empty_done_end", done, 0);
        chk("empty_busy_end", busy, 0);
        chk("empty_reads_left", q_addr.size(), 0);

        // Start while busy is ignored: pulse start again during a packet
        mem[13'h0060] = 32'h0000_0002;
        mem[13'h0061] = 32'h1111_2222;
        mem[13'h0062] = 32'h3333_4444;
        q_addr.push_back(13'h0060);
        q_addr.push_back(13'h0061);
        q_addr.push_back(13'h0062);
        q_exp.push_back('{32'h1111_2222, 1'b0});
        q_exp.push_back('{32'h3333_4444, 1'b1});
        pulse_start(13'h0060);
        start = 1'b1; base_address = 13'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (done) begin hit = 1'b1; break; end
        end
        chk("busy_start_done", hit, 1);
        @(posedge clk); #1;
        chk("busy_start_beats", q_exp.size(), 0);
        chk("busy_start_reads", q_addr.size(), 0);

        // Reset in the middle of the second beat of an 8-word packet
        q_addr.push_back(13'h0600);
        mem[13'h0600] = 32'h0000_0008;
        for (int k = 1; k <= 8; k++) begin
            mem[13'h0600 + 13'(k)] = 32'hC0DE_0000 + k;
            q_addr.push_back(13'h0600 + 13'(k));
            q_exp.push_back('{32'hC0DE_0000 + k, (k == 8)});
        end
        rdy_mode = 0;
        b0 = beats_seen;
        pulse_start(13'h0600);
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (beats_seen >= b0 + 1 && out_valid) begin hit = 1'b1; break; end
        end
        chk("second_beat_seen", hit, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_rden", rd_enable, 0);
        chk("mid_rst_addr", rd_address, 0);
        q_exp.delete();
        q_addr.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_pkt(13'h0700, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bram_packet_reader

// File: doc/bram_packet_reader.md
# bram_packet_reader

PL-side reader for the PS↔PL shared-BRAM channel in hwdbg.
- On a start pulse it fetches a length-prefixed packet from the BRAM read port and streams the payload words out over a valid/ready interface.
- It handles the fixed BRAM read latency, 13-bit address wrap-around and backpressure.
- It sits between the shared BRAM interface (as its read-port client) and the hwdbg command decoder.

## Interface
Parameters:
- ADDR_WIDTH, 12, BRAM address width; address buses are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 32, word width; must be ≥ 16.
- RD_LATENCY, 3, clock edges from the edge that registers rd_address to the edge that samples rd_data.
- MAX_LEN, 1024, largest legal payload length in words.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_address  in  ADDR_WIDTH+1  header location; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; 1 = length exceeded MAX_LEN.
- rd_address  out  ADDR_WIDTH+1  BRAM read address, registered.
- rd_enable  out  1  high when rd_address carries a new request.
- rd_data  in  DATA_WIDTH  BRAM read data.
- out_data  out  DATA_WIDTH  payload word.
- out_valid  out  1  payload word available.
- out_ready  in  1  consumer accepts word.
- out_last  out  1  marks the final payload word; qualified by out_valid.

## Operation
- Packet format: the word at base_address is the header, with LEN = header[15:0]. The payload is at base_address+1 … base_address+LEN. Upper header bits are ignored.
- Address arithmetic is modulo 2^(ADDR_WIDTH+1); the address after all-ones is 0.
- The block never drives writes. The write-side owner holds enable_write low while busy=1.
- States:
  - IDLE: on start, go to HDR_WAIT.
  - HDR_WAIT: wait for the header; then, if LEN=0, go to DONE with error=0; if LEN>MAX_LEN, go to DONE with error=1; otherwise go to FETCH.
  - FETCH: issue payload reads and hand words to the output; after the last word is accepted, go to DONE.
  - DONE: pulse done, then go to IDLE.
- start while busy=1 is ignored.
- A word-remaining counter (16 bits) decrements on each accepted beat. out_last = out_valid && remaining==1.
- Beats are delivered strictly in address order, and each address is read exactly once per packet.

## Timing
- Reset values:
  - busy, done, error, rd_enable, out_valid, out_last: 0.
  - rd_address, out_data: 0.
  - State: IDLE.
- Reset assertion clears all of the above immediately, at any point in a packet. In-flight reads are discarded.
- Header read: start sampled at edge E → rd_address=base, rd_enable=1 after E. The header is sampled at E+RD_LATENCY.
- Without prefetch:
  - One outstanding read at a time.
  - Each payload word is requested the cycle after the previous beat is accepted, and is presented RD_LATENCY cycles after its request.
  - out_valid stays high, with out_data and out_last stable, until out_ready=1.
- done asserts the cycle after the final handshake (or after header evaluation when LEN=0 or on error). busy drops in the same cycle done deasserts.
- rd_enable is high for exactly one cycle per request.

## Configuration
- BRAM_PACKET_READER_PREFETCH_EN defined:
  - A 4-entry prefetch FIFO is compiled in.
  - Reads issue back-to-back while (FIFO occupancy + reads in flight) < 4.
  - With out_ready held high, sustained throughput is 1 beat/clk after the first RD_LATENCY+1 cycles.
  - Ordering, out_last, done and error behaviour are unchanged.
- Undefined: single-outstanding mode as in Timing; no FIFO storage.

## Structure
- Shared package bram_reader_pkg holds:
  - state enum (IDLE, HDR_WAIT, FETCH, DONE);
  - header LEN field position and width constants;
  - prefetch depth constant (4).
- One sub-module, bram_reader_prefetch_fifo: synchronous FIFO with in-flight credit counting, instantiated only under BRAM_PACKET_READER_PREFETCH_EN.

## Test plan
- Basic packet: mem[0x010]=3, mem[0x011..0x013]=A,B,C, base=0x010, out_ready=1 → beats A,B,C; out_last only on C; one done pulse; error=0.
- Empty packet: header LEN=0 → no out_valid; done at E+RD_LATENCY+1; error=0.
- Oversize: header LEN=1025 (MAX_LEN=1024) → no beats; done with error=1; no payload reads issued.
- Wrap: base=0x1FFE, LEN=2 → reads at 0x1FFF then 0x0000; beats in that order.
- Backpressure: LEN=4 with out_ready pattern 1,0,0,1,0,1,1 → out_data/out_last held stable while stalled; all 4 words delivered exactly once; with the prefetch macro on, 4 beats in 4 consecutive cycles once ready is held.
- Reset mid-packet: reset_n low during the second beat of LEN=8 → all outputs 0 immediately; a subsequent start on a LEN=1 packet completes correctly.
